id_stage: RTL and testbench

Instruction-decode stage of the RV32I pipeline, placed between fetch and execute and wrapped around the register file.
- Latches fetched instructions into an internal IF/ID register.
- Decodes the held instruction and drives the register file read ports (re1/re2/raddr1/raddr2).
- Captures operands, immediate and control fields into an ID/EX register for the execute stage.
- Detects load-use and write-back hazards, inserts bubbles and back-pressures fetch.

---
 rtl/rv_pkg.sv | 51 +++++
 rtl/id_stage_if.sv | 33 +++
 rtl/id_decode.sv | 72 +++++++
 rtl/id_stage.sv | 163 ++++++++++++++++
 tb/tb_id_stage.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I decode definitions.
//   XLEN        datapath width
//   OPC_*       major opcode values (inst[6:0])
//   imm_fmt_t   immediate encoding selected by the decoder
//   id_state_t  decode-stage FSM states
//   idex_t      contents of the ID/EX pipeline register
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_R,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_t;

    typedef enum logic {
        RUN,
        STALL
    } id_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            we;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic            is_load;
        logic            illegal;
    } idex_t;

endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: decode -> execute bundle (ID/EX register contents + ready).
//   master  driven by id_stage (all ex_* outputs, ex_ready input)
//   slave   seen by the execute stage
interface id_stage_if;
    import rv_pkg::*;

    logic            ex_ready;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_op1;
    logic [XLEN-1:0] ex_op2;
    logic [XLEN-1:0] ex_imm;
    logic [4:0]      ex_rd;
    logic            ex_we;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_funct3;
    logic            ex_funct7b5;
    logic            ex_is_load;
    logic            ex_illegal;

    modport master (
        input  ex_ready,
        output ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd, ex_we,
               ex_opcode, ex_funct3, ex_funct7b5, ex_is_load, ex_illegal
    );

    modport slave (
        output ex_ready,
        input  ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd, ex_we,
               ex_opcode, ex_funct3, ex_funct7b5, ex_is_load, ex_illegal
    );

endinterface

// File: rtl/id_decode.sv
// id_decode: combinational RV32I field decoder.
//   inst      instruction word held in IF/ID
//   uses_rs1  instruction reads rs1
//   uses_rs2  instruction reads rs2
//   writes_rd instruction produces a result in rd (before the x0 check)
//   illegal   opcode not recognised
//   imm       sign-extended immediate (0 for R-type / illegal)
module id_decode
    import rv_pkg::*;
(
    input  logic [XLEN-1:0] inst,
    output logic            uses_rs1,
    output logic            uses_rs2,
    output logic            writes_rd,
    output logic            illegal,
    output logic [XLEN-1:0] imm
);

    logic [6:0] opcode;
    imm_fmt_t   fmt;

    assign opcode = inst[6:0];

    always_comb begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b0;
        writes_rd = 1'b1;
        illegal   = 1'b0;
        fmt       = IMM_R;
        case (opcode)
            OPC_LOAD, OPC_JALR, OPC_OP_IMM, OPC_SYSTEM: fmt = IMM_I;
            OPC_OP: uses_rs2 = 1'b1;
            OPC_STORE: begin
                uses_rs2  = 1'b1;
                writes_rd = 1'b0;
                fmt       = IMM_S;
            end
            OPC_BRANCH: begin
                uses_rs2  = 1'b1;
                writes_rd = 1'b0;
                fmt       = IMM_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                uses_rs1 = 1'b0;
                fmt      = IMM_U;
            end
            OPC_JAL: begin
                uses_rs1 = 1'b0;
                fmt      = IMM_J;
            end
            default: begin
                // unknown opcodes must not touch the register file
                uses_rs1  = 1'b0;
                writes_rd = 1'b0;
                illegal   = 1'b1;
            end
        endcase
    end

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'b0};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I instruction-decode stage wrapped around the register file.
//   clk, rst            pipeline clock; asynchronous active-low reset
//   if_valid/inst/pc    fetch side; id_ready = IF/ID accepts this cycle
//   flush               redirect; kills IF/ID and ID/EX on the next edge
//   re1/re2, raddr1/2   register file read ports; rdata1/2 combinational
//   wb_we/waddr/wdata   write-back port (also written into the regfile)
//   ex                  id_stage_if.master: ID/EX register to execute
// Build option: ID_FWD_EN defined -> write-back data is bypassed into the
// operands; undefined -> a write-back RAW costs a one-cycle stall instead.
//
// state | meaning
// RUN   | normal issue; hazards are evaluated every cycle
// STALL | bubble was just inserted; the held instruction issues now
module id_stage
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_inst,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            flush,
    output logic            re1,
    output logic            re2,
    output logic [4:0]      raddr1,
    output logic [4:0]      raddr2,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    input  logic            wb_we,
    input  logic [4:0]      wb_waddr,
    input  logic [XLEN-1:0] wb_wdata,
    id_stage_if.master      ex
);

    logic            ifid_valid;
    logic [XLEN-1:0] ifid_inst;
    logic [XLEN-1:0] ifid_pc;

    idex_t     idex_q, idex_d;
    id_state_t state_q, state_d;

    logic            uses_rs1, uses_rs2, writes_rd, illegal;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1, rs2, rd;
    logic            rs1_used, rs2_used;
    logic            wb_hit1, wb_hit2;
    logic            load_use, wb_raw, stall;
    logic [XLEN-1:0] op1, op2;

    id_decode u_decode (
        .inst      (ifid_inst),
        .uses_rs1  (uses_rs1),
        .uses_rs2  (uses_rs2),
        .writes_rd (writes_rd),
        .illegal   (illegal),
        .imm       (imm)
    );

    assign rs1 = ifid_inst[19:15];
    assign rs2 = ifid_inst[24:20];
    assign rd  = ifid_inst[11:7];

    assign rs1_used = ifid_valid && uses_rs1;
    assign rs2_used = ifid_valid && uses_rs2;

    assign re1    = rs1_used;
    assign re2    = rs2_used;
    assign raddr1 = rs1;
    assign raddr2 = rs2;

    assign load_use = idex_q.valid && idex_q.is_load && (idex_q.rd != 5'd0) &&
                      ((rs1_used && (rs1 == idex_q.rd)) ||
                       (rs2_used && (rs2 == idex_q.rd)));

    assign wb_hit1 = wb_we && (wb_waddr != 5'd0) && (wb_waddr == rs1);
    assign wb_hit2 = wb_we && (wb_waddr != 5'd0) && (wb_waddr == rs2);

`ifdef ID_FWD_EN
    assign wb_raw = 1'b0;
    assign op1    = (rs1 == 5'd0) ? '0 : (wb_hit1 ? wb_wdata : rdata1);
    assign op2    = (rs2 == 5'd0) ? '0 : (wb_hit2 ? wb_wdata : rdata2);
`else
    // without the bypass the write-back data only reaches us through the
    // register file one cycle later
    logic wb_wdata_unused;
    assign wb_wdata_unused = ^wb_wdata;
    assign wb_raw = (rs1_used && wb_hit1) || (rs2_used && wb_hit2);
    assign op1    = (rs1 == 5'd0) ? '0 : rdata1;
    assign op2    = (rs2 == 5'd0) ? '0 : rdata2;
`endif

    // STALL never re-stalls: the bubble already cleared the load from ID/EX
    // and the write-back has committed, so the held instruction issues.
    assign stall    = (state_q == RUN) && (load_use || wb_raw);
    assign id_ready = ex.ex_ready && !stall;

    always_comb begin
        state_d = RUN;
        idex_d  = idex_q;
        if (flush) begin
            idex_d = '0;
        end else if (ex.ex_ready) begin
            idex_d = '0;
            if (stall) begin
                state_d = STALL;
            end else if (ifid_valid) begin
                idex_d.valid    = 1'b1;
                idex_d.pc       = ifid_pc;
                idex_d.op1      = op1;
                idex_d.op2      = op2;
                idex_d.imm      = imm;
                idex_d.rd       = rd;
                idex_d.we       = writes_rd && (rd != 5'd0);
                idex_d.opcode   = ifid_inst[6:0];
                idex_d.funct3   = ifid_inst[14:12];
                idex_d.funct7b5 = ifid_inst[30];
                idex_d.is_load  = (ifid_inst[6:0] == OPC_LOAD);
                idex_d.illegal  = illegal;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            idex_q  <= '0;
        end else begin
            state_q <= state_d;
            idex_q  <= idex_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifid_valid <= 1'b0;
            ifid_inst  <= '0;
            ifid_pc    <= '0;
        end else if (flush) begin
            ifid_valid <= 1'b0;
        end else if (id_ready) begin
            ifid_valid <= if_valid;
            if (if_valid) begin
                ifid_inst <= if_inst;
                ifid_pc   <= if_pc;
            end
        end
    end

    assign ex.ex_valid    = idex_q.valid;
    assign ex.ex_pc       = idex_q.pc;
    assign ex.ex_op1      = idex_q.op1;
    assign ex.ex_op2      = idex_q.op2;
    assign ex.ex_imm      = idex_q.imm;
    assign ex.ex_rd       = idex_q.rd;
    assign ex.ex_we       = idex_q.we;
    assign ex.ex_opcode   = idex_q.opcode;
    assign ex.ex_funct3   = idex_q.funct3;
    assign ex.ex_funct7b5 = idex_q.funct7b5;
    assign ex.ex_is_load  = idex_q.is_load;
    assign ex.ex_illegal  = idex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed vectors and hand-written sequences for id_stage.
module tb_id_stage;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_inst, if_pc;
    logic        id_ready;
    logic        flush;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;

    logic [31:0] rf [32];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign rdata1 = rf[raddr1];
    assign rdata2 = rf[raddr2];

    id_stage_if ex_bus ();

    id_stage dut (
        .clk      (clk),
        .rst      (rst),
        .if_valid (if_valid),
        .if_inst  (if_inst),
        .if_pc    (if_pc),
        .id_ready (id_ready),
        .flush    (flush),
        .re1      (re1),
        .re2      (re2),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .rdata1   (rdata1),
        .rdata2   (rdata2),
        .wb_we    (wb_we),
        .wb_waddr (wb_waddr),
        .wb_wdata (wb_wdata),
        .ex       (ex_bus)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] re1;
        logic [31:0] re2;
        logic [31:0] imm;
        logic [31:0] we;
        logic [31:0] rd;
        logic [31:0] ill;
        logic [31:0] ld;
        logic [31:0] op1;
        logic [31:0] op2;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst             = 1'b1;
        if_valid        = 1'b0;
        if_inst         = '0;
        if_pc           = '0;
        flush           = 1'b0;
        wb_we           = 1'b0;
        wb_waddr        = '0;
        wb_wdata        = '0;
        ex_bus.ex_ready = 1'b1;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + 32'(i);
        rf[0] = 32'hFFFF_FFFF;

        //          inst          pc    re1 re2 imm           we rd ill ld op1      op2
        vecs[0] = '{32'h00500093, 'h100, 1, 0, 32'h00000005, 1, 1,  0, 0, 'h0,    'h1005};
        vecs[1] = '{32'hFE208CE3, 'h104, 1, 1, 32'hFFFFFFF8, 0, 25, 0, 0, 'h1001, 'h1002};
        vecs[2] = '{32'h0000007F, 'h108, 0, 0, 32'h00000000, 0, 0,  1, 0, 'h0,    'h0};
        vecs[3] = '{32'h0000A103, 'h10C, 1, 0, 32'h00000000, 1, 2,  0, 1, 'h1001, 'h0};
        vecs[4] = '{32'hFE51AE23, 'h110, 1, 1, 32'hFFFFFFFC, 0, 28, 0, 0, 'h1003, 'h1005};
        vecs[5] = '{32'h123453B7, 'h114, 0, 0, 32'h12345000, 1, 7,  0, 0, 'h1008, 'h1003};
        vecs[6] = '{32'h010000EF, 'h118, 0, 0, 32'h00000010, 1, 1,  0, 0, 'h0,    'h1010};
        vecs[7] = '{32'h00208033, 'h11C, 1, 1, 32'h00000000, 0, 0,  0, 0, 'h1001, 'h1002};
        vecs[8] = '{32'hFFFFF197, 'h120, 0, 0, 32'hFFFFF000, 1, 3,  0, 0, 'h101F, 'h101F};

        // asynchronous reset, no clock edge yet
        #1 rst = 1'b0;
        #1;
        chk("reset ex_valid", 32'(ex_bus.ex_valid), 0);
        chk("reset id_ready", 32'(id_ready), 1);
        chk("reset re1", 32'(re1), 0);
        chk("reset raddr1", 32'(raddr1), 0);
        chk("reset ex_pc", ex_bus.ex_pc, 0);
        @(negedge clk);
        rst = 1'b1;
        step();

        for (int i = 0; i < 9; i++) begin
            if_valid = 1'b1;
            if_inst  = vecs[i].inst;
            if_pc    = vecs[i].pc;
            step();
            if_valid = 1'b0;
            #1;
            chk($sformatf("v%0d re1", i), 32'(re1), vecs[i].re1);
            chk($sformatf("v%0d re2", i), 32'(re2), vecs[i].re2);
            chk($sformatf("v%0d raddr1", i), 32'(raddr1), 32'(vecs[i].inst[19:15]));
            chk($sformatf("v%0d raddr2", i), 32'(raddr2), 32'(vecs[i].inst[24:20]));
            chk($sformatf("v%0d id_ready", i), 32'(id_ready), 1);
            step();
            chk($sformatf("v%0d ex_valid", i), 32'(ex_bus.ex_valid), 1);
            chk($sformatf("v%0d ex_pc", i), ex_bus.ex_pc, vecs[i].pc);
            chk($sformatf("v%0d ex_imm", i), ex_bus.ex_imm, vecs[i].imm);
            chk($sformatf("v%0d ex_we", i), 32'(ex_bus.ex_we), vecs[i].we);
            chk($sformatf("v%0d ex_rd", i), 32'(ex_bus.ex_rd), vecs[i].rd);
            chk($sformatf("v%0d ex_illegal", i), 32'(ex_bus.ex_illegal), vecs[i].ill);
            chk($sformatf("v%0d ex_is_load", i), 32'(ex_bus.ex_is_load), vecs[i].ld);
            chk($sformatf("v%0d ex_op1", i), ex_bus.ex_op1, vecs[i].op1);
            chk($sformatf("v%0d ex_op2", i), ex_bus.ex_op2, vecs[i].op2);
            chk($sformatf("v%0d ex_opcode", i), 32'(ex_bus.ex_opcode), 32'(vecs[i].inst[6:0]));
        end
        step();

        // load-use: LW x2,0(x1) then ADD x3,x2,x2
        if_valid = 1'b1;
        if_inst  = 32'h0000A103;
        if_pc    = 32'h300;
        step();
        if_inst = 32'h002101B3;
        if_pc   = 32'h304;
        step();
        #1;
        chk("lu hazard id_ready", 32'(id_ready), 0);
        chk("lu load in idex", 32'(ex_bus.ex_is_load), 1);
        if_inst = 32'h00000013;
        if_pc   = 32'h308;
        step();
        #1;
        chk("lu bubble ex_valid", 32'(ex_bus.ex_valid), 0);
        chk("lu stall id_ready", 32'(id_ready), 1);
        chk("lu held raddr1", 32'(raddr1), 2);
        step();
        chk("lu add ex_valid", 32'(ex_bus.ex_valid), 1);
        chk("lu add ex_pc", ex_bus.ex_pc, 32'h304);
        chk("lu add ex_rd", 32'(ex_bus.ex_rd), 3);
        chk("lu add ex_op1", ex_bus.ex_op1, 32'h1002);
        if_valid = 1'b0;
        step();
        step();

        // write-back RAW: ADD x5,x6,x7 while WB writes x6
        rf[6]    = 32'h0;
        if_valid = 1'b1;
        if_inst  = 32'h007302B3;
        if_pc    = 32'h400;
        step();
        if_valid = 1'b0;
        wb_we    = 1'b1;
        wb_waddr = 5'd6;
        wb_wdata = 32'hDEADBEEF;
        #1;
`ifdef ID_FWD_EN
        chk("wb id_ready", 32'(id_ready), 1);
`else
        chk("wb id_ready", 32'(id_ready), 0);
`endif
        step();
        rf[6] = 32'hDEADBEEF;
        wb_we = 1'b0;
        #1;
`ifdef ID_FWD_EN
        chk("wb ex_valid", 32'(ex_bus.ex_valid), 1);
`else
        chk("wb bubble ex_valid", 32'(ex_bus.ex_valid), 0);
        step();
        chk("wb retry ex_valid", 32'(ex_bus.ex_valid), 1);
`endif
        chk("wb ex_op1", ex_bus.ex_op1, 32'hDEADBEEF);
        chk("wb ex_op2", ex_bus.ex_op2, 32'h1007);
        chk("wb ex_pc", ex_bus.ex_pc, 32'h400);
        step();

        // backpressure for three cycles, then flush during the hold
        if_valid = 1'b1;
        if_inst  = 32'h00500093;
        if_pc    = 32'h500;
        step();
        if_inst = 32'h123453B7;
        if_pc   = 32'h504;
        step();
        ex_bus.ex_ready = 1'b0;
        if_inst = 32'h010000EF;
        if_pc   = 32'h508;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d id_ready", k), 32'(id_ready), 0);
            step();
            chk($sformatf("bp%0d ex_valid", k), 32'(ex_bus.ex_valid), 1);
            chk($sformatf("bp%0d ex_pc", k), ex_bus.ex_pc, 32'h500);
            chk($sformatf("bp%0d ex_imm", k), ex_bus.ex_imm, 32'h5);
            chk($sformatf("bp%0d ex_rd", k), 32'(ex_bus.ex_rd), 1);
        end
        chk("bp ifid held raddr1", 32'(raddr1), 8);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush ex_valid", 32'(ex_bus.ex_valid), 0);
        ex_bus.ex_ready = 1'b1;
        if_valid = 1'b0;
        step();
        chk("flush ifid killed", 32'(ex_bus.ex_valid), 0);
        step();

        // asynchronous reset during a load-use stall
        if_valid = 1'b1;
        if_inst  = 32'h0000A103;
        if_pc    = 32'h600;
        step();
        if_inst = 32'h002101B3;
        if_pc   = 32'h604;
        step();
        #1;
        chk("rs pre id_ready", 32'(id_ready), 0);
        rst = 1'b0;
        #1;
        chk("rs ex_valid", 32'(ex_bus.ex_valid), 0);
        chk("rs id_ready", 32'(id_ready), 1);
        chk("rs re1", 32'(re1), 0);
        #1;
        rst      = 1'b1;
        if_valid = 1'b0;
        step();
        chk("rs after ex_valid", 32'(ex_bus.ex_valid), 0);
        chk("rs after id_ready", 32'(id_ready), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
